// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the FSM state encoding, the R-format field positions and the known opcodes.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StIssue = 2'd2,
        StHalt  = 2'd3
    } fetch_state_e;

    // MSB position of each field inside the 32-bit instruction word
    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned FUNCT_MSB = 5;

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SW   = 6'h02;
    localparam logic [5:0] OP_LW   = 6'h04;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_fields_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OP_MSB -: 6];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Purely combinational splitter of a 32-bit instruction word into MIPS R-format fields.
// Shared by the fetch unit and its reference model.
module instr_field_split
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] word,
    output logic [5:0]  op,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct
);

    instr_fields_t fields;

    always_comb begin
        fields.op    = opcode_of(word);
        fields.rs    = word[RS_MSB -: 5];
        fields.rt    = word[RT_MSB -: 5];
        fields.rd    = word[RD_MSB -: 5];
        fields.shamt = word[SHAMT_MSB -: 5];
        fields.funct = word[FUNCT_MSB -: 6];
    end

    assign op    = fields.op;
    assign rs    = fields.rs;
    assign rt    = fields.rt;
    assign rd    = fields.rd;
    assign shamt = fields.shamt;
    assign funct = fields.funct;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: fetches words over req/ack, latches and splits them,
// presents each for one issue cycle, advances the PC and stops on the HALT opcode.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]       HALT_OP  = OP_HALT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic              instr_valid,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       issue_cnt
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [15:0]       cnt_q, cnt_d;

    logic fetch_done;
    logic issue_adv;

    assign fetch_done = (state_q == StFetch) && imem_ack;
    assign issue_adv  = (state_q == StIssue) && !hold;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the HALT decision looks at the word being latched this edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    state_d = (opcode_of(imem_rdata) == HALT_OP) ? StHalt : StIssue;
                end
            end
            StIssue: begin
                if (!hold) begin
                    state_d = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output logic
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StFetch: begin
                imem_req = 1'b1;
                busy     = 1'b1;
            end
            StIssue: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath next-state: instruction register, PC and saturating issue counter
    always_comb begin
        ir_d  = ir_q;
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (fetch_done) begin
            ir_d = imem_rdata;
        end
        if (issue_adv) begin
            pc_d = pc_q + ADDR_W'(1);
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
        end
    end

    instr_field_split u_split (
        .word  (ir_q),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .shamt (shamt),
        .funct (funct)
    );

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed-vector bench for instr_fetch_unit: a default instance with a delay-programmable
// memory responder plus a narrow-PC instance for the wrap case.
module tb_instr_fetch_unit;

    localparam logic [31:0] ADD_W  = 32'h0443_0800;  // add rd=1, rs=2, rt=3
    localparam logic [31:0] SW_W   = 32'h0841_0000;  // sw 1,0(2)
    localparam logic [31:0] LW_W   = 32'h1041_0000;  // lw 1,0(2)
    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic        instr_valid, busy, halted;
    logic [7:0]  pc;
    logic [15:0] issue_cnt;

    logic        start2 = 1'b0;
    logic        imem_req2;
    logic [1:0]  imem_addr2;
    logic        imem_ack2 = 1'b0;
    logic [31:0] imem_rdata2 = '0;
    logic [5:0]  op2;
    logic [4:0]  rs2, rt2, rd2, shamt2;
    logic [5:0]  funct2;
    logic        instr_valid2, busy2, halted2;
    logic [1:0]  pc2;
    logic [15:0] issue_cnt2;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [4];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          force_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .instr_valid(instr_valid), .busy(busy), .halted(halted),
        .pc(pc), .issue_cnt(issue_cnt)
    );

    instr_fetch_unit #(.ADDR_W(2), .RESET_PC(2'd3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .hold(1'b0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
        .imem_rdata(imem_rdata2), .op(op2), .rs(rs2), .rt(rt2), .rd(rd2), .shamt(shamt2),
        .funct(funct2), .instr_valid(instr_valid2), .busy(busy2), .halted(halted2),
        .pc(pc2), .issue_cnt(issue_cnt2)
    );

    // Memory responders drive on the falling edge, so the DUT sees stable inputs
    always @(negedge clk) begin
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
        end else if (imem_req) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        imem_ack2   = imem_req2;
        imem_rdata2 = mem2[imem_addr2];
    end

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        force_ack = 1'b0;
        ack_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pc !== 8'd0) begin n_bad++; $display("FAIL reset_pc: got %0h want 0", pc); end
        n_cmp++; if ({op, rs, rt, rd, shamt, funct} !== 32'd0) begin
            n_bad++; $display("FAIL reset_fields: got op=%0h rs=%0h rd=%0h want 0", op, rs, rd); end
        n_cmp++; if ({imem_req, instr_valid, busy, halted} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000",
                              {imem_req, instr_valid, busy, halted}); end
        n_cmp++; if (issue_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", issue_cnt); end
        n_cmp++; if (pc2 !== 2'd3) begin n_bad++; $display("FAIL reset_pc2: got %0d want 3", pc2); end
    endtask

    task automatic test_first_fetch();
        int lat;
        bit seen;
        do_reset();
        mem[0] = ADD_W;
        mem[1] = HALT_W;
        start = 1'b1;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (instr_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL first_seen: got %0b want 1", seen); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL first_latency: got %0d want 2", lat); end
        n_cmp++; if ({op, rs, rt, rd, shamt, funct} !== {6'h01, 5'd2, 5'd3, 5'd1, 5'd0, 6'd0}) begin
            n_bad++; $display("FAIL first_fields: got %0h/%0d/%0d/%0d/%0d/%0h want 01/2/3/1/0/0",
                              op, rs, rt, rd, shamt, funct); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL first_busy: got %0b want 1", busy); end
        @(posedge clk); #1;
        n_cmp++; if (pc !== 8'd1) begin n_bad++; $display("FAIL first_pc: got %0d want 1", pc); end
        n_cmp++; if (issue_cnt !== 16'd1) begin n_bad++; $display("FAIL first_cnt: got %0d want 1", issue_cnt); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL first_pulse: got %0b want 0", instr_valid); end
        for (int i = 0; i < 10 && !halted; i++) begin @(posedge clk); #1; end
        n_cmp++; if ({halted, pc, issue_cnt} !== {1'b1, 8'd1, 16'd1}) begin
            n_bad++; $display("FAIL first_halt: got halted=%0b pc=%0d cnt=%0d want 1/1/1",
                              halted, pc, issue_cnt); end
    endtask

    task automatic test_program();
        logic [5:0] ops [3];
        int npulse;
        do_reset();
        mem[0] = ADD_W; mem[1] = SW_W; mem[2] = LW_W; mem[3] = HALT_W;
        ack_delay = 3;
        npulse = 0;
        start = 1'b1;
        for (int i = 0; i < 100 && !halted; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (instr_valid) begin
                if (npulse < 3) ops[npulse] = op;
                npulse++;
            end
        end
        n_cmp++; if (npulse !== 3) begin n_bad++; $display("FAIL prog_pulses: got %0d want 3", npulse); end
        n_cmp++; if ({ops[0], ops[1], ops[2]} !== {6'h01, 6'h02, 6'h04}) begin
            n_bad++; $display("FAIL prog_ops: got %0h %0h %0h want 01 02 04", ops[0], ops[1], ops[2]); end
        n_cmp++; if ({halted, pc, issue_cnt} !== {1'b1, 8'd3, 16'd3}) begin
            n_bad++; $display("FAIL prog_halt: got halted=%0b pc=%0d cnt=%0d want 1/3/3",
                              halted, pc, issue_cnt); end
        n_cmp++; if ({imem_req, busy, instr_valid} !== 3'b000) begin
            n_bad++; $display("FAIL prog_halt_flags: got %b want 000", {imem_req, busy, instr_valid}); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({halted, imem_req, pc, issue_cnt} !== {1'b1, 1'b0, 8'd3, 16'd3}) begin
            n_bad++; $display("FAIL prog_restart: got halted=%0b req=%0b pc=%0d cnt=%0d want 1/0/3/3",
                              halted, imem_req, pc, issue_cnt); end
    endtask

    task automatic test_hold();
        int nvalid;
        int nheld;
        do_reset();
        mem[0] = ADD_W; mem[1] = SW_W; mem[2] = LW_W; mem[3] = HALT_W;
        nvalid = 0;
        start = 1'b1;
        for (int i = 0; i < 20 && nvalid < 2; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (instr_valid) nvalid++;
        end
        n_cmp++; if (nvalid !== 2) begin n_bad++; $display("FAIL hold_reach: got %0d want 2", nvalid); end
        hold = 1'b1;
        nheld = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (instr_valid && op === 6'h02 && rt === 5'd1 && pc === 8'd1 && issue_cnt === 16'd1)
                nheld++;
        end
        hold = 1'b0;
        n_cmp++; if (nheld !== 5) begin n_bad++; $display("FAIL hold_stable: got %0d cycles want 5", nheld); end
        @(posedge clk); #1;
        n_cmp++; if ({instr_valid, pc, issue_cnt} !== {1'b0, 8'd2, 16'd2}) begin
            n_bad++; $display("FAIL hold_release: got valid=%0b pc=%0d cnt=%0d want 0/2/2",
                              instr_valid, pc, issue_cnt); end
        for (int i = 0; i < 20 && !halted; i++) begin @(posedge clk); #1; end
        n_cmp++; if (issue_cnt !== 16'd3) begin n_bad++; $display("FAIL hold_final_cnt: got %0d want 3", issue_cnt); end
    endtask

    task automatic test_wrap();
        int nvalid;
        do_reset();
        mem2[3] = ADD_W;
        mem2[0] = HALT_W;
        nvalid = 0;
        start2 = 1'b1;
        for (int i = 0; i < 20 && !halted2; i++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            if (instr_valid2) nvalid++;
        end
        n_cmp++; if (nvalid !== 1) begin n_bad++; $display("FAIL wrap_issues: got %0d want 1", nvalid); end
        n_cmp++; if ({halted2, pc2, issue_cnt2} !== {1'b1, 2'd0, 16'd1}) begin
            n_bad++; $display("FAIL wrap_halt: got halted=%0b pc=%0d cnt=%0d want 1/0/1",
                              halted2, pc2, issue_cnt2); end
    endtask

    task automatic test_reset_midfetch();
        bit seen;
        do_reset();
        mem[0] = ADD_W;
        mem[1] = SW_W;
        seen = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (instr_valid) seen = 1'b1;
        end
        ack_delay = 100;
        @(posedge clk); #1;
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 8'd1}) begin
            n_bad++; $display("FAIL mid_fetch: got req=%0b addr=%0d want 1/1", imem_req, imem_addr); end
        rst = 1'b1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({imem_req, instr_valid, busy} !== 3'b000) begin
            n_bad++; $display("FAIL mid_flags: got %b want 000", {imem_req, instr_valid, busy}); end
        n_cmp++; if ({pc, issue_cnt} !== {8'd0, 16'd0}) begin
            n_bad++; $display("FAIL mid_pc_cnt: got pc=%0d cnt=%0d want 0/0", pc, issue_cnt); end
        n_cmp++; if ({op, rs, rt, rd, shamt, funct} !== 32'd0) begin
            n_bad++; $display("FAIL mid_fields: got op=%0h rt=%0h want 0", op, rt); end
        rst = 1'b0;
        force_ack = 1'b0;
        ack_delay = 0;
        @(posedge clk); #1;
        n_cmp++; if ({instr_valid, imem_req, busy} !== 3'b000) begin
            n_bad++; $display("FAIL mid_after: got %b want 000", {instr_valid, imem_req, busy}); end
    endtask

    task automatic test_ack_outside_fetch();
        do_reset();
        mem[0] = ADD_W;
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_ack = 1'b0;
        n_cmp++; if ({busy, imem_req, instr_valid, op, rd} !== {3'b000, 6'd0, 5'd0}) begin
            n_bad++; $display("FAIL idle_ack: got busy=%0b req=%0b op=%0h rd=%0d want 0/0/0/0",
                              busy, imem_req, op, rd); end
        mem[0] = HALT_W;
        start = 1'b1;
        for (int i = 0; i < 10 && !halted; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_cmp++; if ({halted, op} !== {1'b1, 6'h3F}) begin
            n_bad++; $display("FAIL halt_reach: got halted=%0b op=%0h want 1/3f", halted, op); end
        mem[0] = ADD_W;
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_ack = 1'b0;
        n_cmp++; if ({halted, busy, op, rs, rd, pc, issue_cnt} !==
                     {2'b10, 6'h3F, 5'd0, 5'd0, 8'd0, 16'd0}) begin
            n_bad++; $display("FAIL halt_ack: got halted=%0b busy=%0b op=%0h rs=%0d rd=%0d pc=%0d cnt=%0d want 1/0/3f/0/0/0/0",
                              halted, busy, op, rs, rd, pc, issue_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = HALT_W;
        for (int i = 0; i < 4; i++) mem2[i] = HALT_W;
        test_reset();
        test_first_fetch();
        test_program();
        test_hold();
        test_wrap();
        test_reset_midfetch();
        test_ack_outside_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
